// File: rtl/cpu_control_if.sv
// Control-sequencer bus bundle: instruction fetch, decoder, ALU, data memory,
// writeback strobes and architectural/debug status of the CPU controller.
interface cpu_control_if #(
    parameter int AW = 16
);
    logic          imem_req;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   ir;
    logic          dec_en;
    logic          dec_halt;
    logic [1:0]    dec_pfix;
    logic [5:0]    dec_opcode;
    logic          alu_start;
    logic          alu_done;
    logic          dmem_req;
    logic          dmem_we;
    logic          dmem_ack;
    logic          branch_cond;
    logic          rf_we;
    logic [AW-1:0] pc;
    logic [31:0]   retired;
    logic          halted;
    logic [2:0]    state;

    modport master (
        output imem_req, ir, dec_en, alu_start, dmem_req, dmem_we, rf_we,
               pc, retired, halted, state,
        input  imem_ack, imem_rdata, dec_halt, dec_pfix, dec_opcode,
               alu_done, dmem_ack, branch_cond
    );

    modport slave (
        input  imem_req, ir, dec_en, alu_start, dmem_req, dmem_we, rf_we,
               pc, retired, halted, state,
        output imem_ack, imem_rdata, dec_halt, dec_pfix, dec_opcode,
               alu_done, dmem_ack, branch_cond
    );
endinterface

// File: rtl/cpu_control.sv
// Multi-cycle control sequencer: owns pc/ir, fetches over req/ack, then steps
// through decode, execute, memory and writeback by prefix class until HLT.
module cpu_control #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_control_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [31:0]   ir_q, ir_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   retired_q, retired_d;
    logic [1:0]    pfix_q, pfix_d;
    logic          op0_q, op0_d;
    logic          alu_first_q, alu_first_d;
    logic [AW-1:0] pc_inc;

    assign pc_inc = pc_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        pfix_d      = pfix_q;
        op0_d       = op0_q;
        alu_first_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                pfix_d = bus.dec_pfix;
                op0_d  = bus.dec_opcode[0];
                if (bus.dec_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d     = S_EXEC;
                    alu_first_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (pfix_q)
                    2'b10: state_d = S_MEM;
                    2'b11: begin
                        pc_d      = bus.branch_cond ? ir_q[AW-1:0] : pc_inc;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                    default: begin
                        // done arriving alongside the start pulse is stale
                        if (!alu_first_q && bus.alu_done) begin
                            state_d = S_WB;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    if (op0_q) begin
                        pc_d      = pc_inc;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_d      = pc_inc;
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            pc_q        <= RESET_PC;
            retired_q   <= '0;
            pfix_q      <= '0;
            op0_q       <= 1'b0;
            alu_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            pfix_q      <= pfix_d;
            op0_q       <= op0_d;
            alu_first_q <= alu_first_d;
        end
    end

    // Reset parks the FSM in FETCH, so the fetch request is masked by rst_n itself
    assign bus.imem_req  = rst_n && (state_q == S_FETCH);
    assign bus.dec_en    = (state_q == S_DECODE);
    assign bus.alu_start = (state_q == S_EXEC) && alu_first_q && !pfix_q[1];
    assign bus.dmem_req  = (state_q == S_MEM);
    assign bus.dmem_we   = (state_q == S_MEM) && op0_q;
    assign bus.rf_we     = (state_q == S_WB);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.ir        = ir_q;
    assign bus.pc        = pc_q;
    assign bus.retired   = retired_q;
    assign bus.state     = state_q;
endmodule
